// File: rtl/cpu_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cpu_controller
//  Description : Instruction-sequencing state machine for the simple RISC
//                CPU. Owns the PC and the instruction register, fetches
//                each instruction from memory, and decodes it into
//                per-cycle Moore control for the Datapath.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    PC_W      PC width; the PC wraps modulo 2^PC_W (PC_W <= 9 expected)
//    RESET_PC  PC value loaded in reset and in the RST state
//  Optional feature
//    CPU_BRANCH_EN  when defined, opcode 001 op 00 is a conditional branch;
//                   when undefined, opcode 001 decodes to HALT
//  Ports
//    clk, reset          clock, synchronous active-high reset
//    read_data    [15:0] memory read data (valid while mem_cmd = READ)
//    datapath_out [15:0] Datapath C register (load/store address source)
//    status_in    [2:0]  Datapath status: [2]=V [1]=N [0]=Z
//    readnum, writenum   register-file selects
//    vsel, bsel, asel    Datapath operand/writeback muxes
//    loada..loads, write Datapath strobes
//    shift, ALUop        shifter / ALU function
//    sximm8, sximm5      sign-extended IR[7:0] / IR[4:0]
//    PC                  current program counter
//    mem_cmd, mem_addr   memory command (00 none, 01 read, 10 write), address
//    halted              high while in the HALT state
// ============================================================================
module cpu_controller #(
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     read_data,
    input  logic [15:0]     datapath_out,
    input  logic [2:0]      status_in,
    output logic [2:0]      readnum,
    output logic [2:0]      writenum,
    output logic [1:0]      vsel,
    output logic [1:0]      bsel,
    output logic            asel,
    output logic            loada,
    output logic            loadb,
    output logic            loadc,
    output logic            loads,
    output logic            write,
    output logic [1:0]      shift,
    output logic [1:0]      ALUop,
    output logic [15:0]     sximm8,
    output logic [15:0]     sximm5,
    output logic [PC_W-1:0] PC,
    output logic [1:0]      mem_cmd,
    output logic [8:0]      mem_addr,
    output logic            halted
);

    localparam logic [PC_W-1:0] c_RESET_PC = PC_W'(RESET_PC);

    localparam logic [1:0] c_MEM_NONE  = 2'b00;
    localparam logic [1:0] c_MEM_READ  = 2'b01;
    localparam logic [1:0] c_MEM_WRITE = 2'b10;

    localparam logic [1:0] c_VSEL_C      = 2'b00;
    localparam logic [1:0] c_VSEL_MDATA  = 2'b10;
    localparam logic [1:0] c_VSEL_SXIMM8 = 2'b11;

    localparam logic [1:0] c_BSEL_B      = 2'b00;
    localparam logic [1:0] c_BSEL_SXIMM5 = 2'b01;

    typedef enum logic [4:0] {
        ST_RST       = 5'd0,
        ST_IF1       = 5'd1,
        ST_IF2       = 5'd2,
        ST_UPDATE_PC = 5'd3,
        ST_DECODE    = 5'd4,
        ST_WIMM      = 5'd5,
        ST_GETA      = 5'd6,
        ST_GETB      = 5'd7,
        ST_EXEC      = 5'd8,
        ST_WREG      = 5'd9,
        ST_ADDR      = 5'd10,
        ST_LADDR     = 5'd11,
        ST_RD1       = 5'd12,
        ST_RD2       = 5'd13,
        ST_GETD      = 5'd14,
        ST_PASS      = 5'd15,
        ST_WR        = 5'd16,
        ST_BRANCH    = 5'd17,
        ST_HALT      = 5'd18
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [15:0]     r_ir;
    logic [PC_W-1:0] r_pc;
    logic [8:0]      r_daddr;

    // ------------------------------------------------------------------
    // Instruction field extraction and class decode
    // ------------------------------------------------------------------
    logic [2:0] w_opcode;
    logic [1:0] w_op;
    logic [2:0] w_rn;
    logic [2:0] w_rd;
    logic [2:0] w_rm;
    logic [2:0] w_cond;

    assign w_opcode = r_ir[15:13];
    assign w_op     = r_ir[12:11];
    assign w_rn     = r_ir[10:8];
    assign w_rd     = r_ir[7:5];
    assign w_rm     = r_ir[2:0];
    assign w_cond   = r_ir[10:8];

    logic w_is_movi;
    logic w_is_movr;
    logic w_is_alu;     // ADD, CMP, AND: need both A and B operands
    logic w_is_cmp;
    logic w_is_mvn;
    logic w_is_ldr;
    logic w_is_str;
    logic w_is_br;

    assign w_is_movi = (w_opcode == 3'b110) && (w_op == 2'b10);
    assign w_is_movr = (w_opcode == 3'b110) && (w_op == 2'b00);
    assign w_is_alu  = (w_opcode == 3'b101) && (w_op != 2'b11);
    assign w_is_cmp  = (w_opcode == 3'b101) && (w_op == 2'b01);
    assign w_is_mvn  = (w_opcode == 3'b101) && (w_op == 2'b11);
    assign w_is_ldr  = (w_opcode == 3'b011) && (w_op == 2'b00);
    assign w_is_str  = (w_opcode == 3'b100) && (w_op == 2'b00);

`ifdef CPU_BRANCH_EN
    assign w_is_br   = (w_opcode == 3'b001) && (w_op == 2'b00);
`else
    assign w_is_br   = 1'b0;
`endif

    // Branch condition, evaluated on status_in during the BRANCH cycle.
    logic w_z, w_n, w_v;
    logic w_br_taken;

    assign w_z = status_in[0];
    assign w_n = status_in[1];
    assign w_v = status_in[2];

    always_comb begin
        w_br_taken = 1'b0;
        case (w_cond)
            3'b000:  w_br_taken = 1'b1;
            3'b001:  w_br_taken = w_z;
            3'b010:  w_br_taken = ~w_z;
            3'b011:  w_br_taken = w_n ^ w_v;
            3'b100:  w_br_taken = (w_n ^ w_v) | w_z;
            default: w_br_taken = 1'b0;
        endcase
    end

    assign sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};
    assign sximm5 = {{11{r_ir[4]}}, r_ir[4:0]};
    assign PC     = r_pc;

    logic [8:0] w_fetch_addr;
    assign w_fetch_addr = 9'(r_pc);

    // Only the low 9 bits of the C register form a data address.
    logic w_unused_dp;
    assign w_unused_dp = ^datapath_out[15:9];

    // ------------------------------------------------------------------
    // State, IR, PC and data-address registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RST;
            r_ir    <= 16'h0000;
            r_pc    <= c_RESET_PC;
            r_daddr <= 9'd0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_RST:       r_pc    <= c_RESET_PC;
                ST_IF2:       r_ir    <= read_data;
                ST_UPDATE_PC: r_pc    <= r_pc + PC_W'(1);
                ST_LADDR:     r_daddr <= datapath_out[8:0];
                // PC has already been incremented past the branch.
                ST_BRANCH: begin
                    if (w_br_taken) begin
                        r_pc <= r_pc + sximm8[PC_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RST:       w_next_state = ST_IF1;
            ST_IF1:       w_next_state = ST_IF2;
            ST_IF2:       w_next_state = ST_UPDATE_PC;
            ST_UPDATE_PC: w_next_state = ST_DECODE;
            ST_DECODE: begin
                if (w_is_movi)                       w_next_state = ST_WIMM;
                else if (w_is_movr || w_is_mvn)      w_next_state = ST_GETB;
                else if (w_is_alu || w_is_ldr || w_is_str)
                                                     w_next_state = ST_GETA;
                else if (w_is_br)                    w_next_state = ST_BRANCH;
                else                                 w_next_state = ST_HALT;
            end
            ST_WIMM:      w_next_state = ST_IF1;
            ST_GETA:      w_next_state = (w_is_ldr || w_is_str) ? ST_ADDR : ST_GETB;
            ST_GETB:      w_next_state = ST_EXEC;
            ST_EXEC:      w_next_state = w_is_cmp ? ST_IF1 : ST_WREG;
            ST_WREG:      w_next_state = ST_IF1;
            ST_ADDR:      w_next_state = ST_LADDR;
            ST_LADDR:     w_next_state = w_is_ldr ? ST_RD1 : ST_GETD;
            ST_RD1:       w_next_state = ST_RD2;
            ST_RD2:       w_next_state = ST_IF1;
            ST_GETD:      w_next_state = ST_PASS;
            ST_PASS:      w_next_state = ST_WR;
            ST_WR:        w_next_state = ST_IF1;
            ST_BRANCH:    w_next_state = ST_IF1;
            ST_HALT:      w_next_state = ST_HALT;
            default:      w_next_state = ST_HALT;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        readnum  = 3'd0;
        writenum = 3'd0;
        vsel     = c_VSEL_C;
        bsel     = c_BSEL_B;
        asel     = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        write    = 1'b0;
        shift    = r_ir[4:3];
        ALUop    = w_op;
        mem_cmd  = c_MEM_NONE;
        mem_addr = 9'd0;
        halted   = 1'b0;
        case (r_state)
            ST_RST: begin
                shift = 2'b00;
                ALUop = 2'b00;
            end
            ST_IF1, ST_IF2: begin
                mem_cmd  = c_MEM_READ;
                mem_addr = w_fetch_addr;
            end
            ST_WIMM: begin
                vsel     = c_VSEL_SXIMM8;
                writenum = w_rn;
                write    = 1'b1;
            end
            ST_GETA: begin
                readnum = w_rn;
                loada   = 1'b1;
            end
            ST_GETB: begin
                readnum = w_rm;
                loadb   = 1'b1;
            end
            ST_EXEC: begin
                // MOV/MVN never loaded A, so feed zero on the A side.
                asel  = w_is_movr | w_is_mvn;
                loads = w_is_cmp;
                loadc = ~w_is_cmp;
            end
            ST_WREG: begin
                vsel     = c_VSEL_C;
                writenum = w_rd;
                write    = 1'b1;
            end
            ST_ADDR: begin
                bsel  = c_BSEL_SXIMM5;
                ALUop = 2'b00;
                loadc = 1'b1;
            end
            ST_RD1: begin
                mem_cmd  = c_MEM_READ;
                mem_addr = r_daddr;
            end
            ST_RD2: begin
                mem_cmd  = c_MEM_READ;
                mem_addr = r_daddr;
                vsel     = c_VSEL_MDATA;
                writenum = w_rd;
                write    = 1'b1;
            end
            ST_GETD: begin
                readnum = w_rd;
                loadb   = 1'b1;
            end
            ST_PASS: begin
                // Store data passes through the ALU unshifted.
                asel  = 1'b1;
                shift = 2'b00;
                ALUop = 2'b00;
                loadc = 1'b1;
            end
            ST_WR: begin
                mem_cmd  = c_MEM_WRITE;
                mem_addr = r_daddr;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: ;
        endcase
        // An instruction interrupted by reset must not touch the register
        // file or memory on the cycle the reset is sampled.
        if (reset) begin
            write   = 1'b0;
            mem_cmd = c_MEM_NONE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_controller
//  Description : Self-checking bench for cpu_controller. A step-list model
//                of each instruction class predicts the outputs every cycle;
//                directed checks pin the model with hand-computed values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_controller;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [15:0] read_data;
    logic [15:0] datapath_out;
    logic [2:0]  status_in;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, bsel, shift, ALUop, mem_cmd;
    logic        asel, loada, loadb, loadc, loads, write, halted;
    logic [15:0] sximm8, sximm5;
    logic [7:0]  PC;
    logic [8:0]  mem_addr;

    logic [15:0] mem [0:511];
    assign read_data = mem[mem_addr];

    cpu_controller #(.PC_W(8), .RESET_PC(0)) dut (
        .clk(clk), .reset(reset), .read_data(read_data),
        .datapath_out(datapath_out), .status_in(status_in),
        .readnum(readnum), .writenum(writenum), .vsel(vsel), .bsel(bsel),
        .asel(asel), .loada(loada), .loadb(loadb), .loadc(loadc),
        .loads(loads), .write(write), .shift(shift), .ALUop(ALUop),
        .sximm8(sximm8), .sximm5(sximm5), .PC(PC), .mem_cmd(mem_cmd),
        .mem_addr(mem_addr), .halted(halted)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit rand_inputs = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: each instruction is 4 fetch/decode cycles followed
    // by a body string, one letter per cycle:
    //   A read Rn->A   B read Rm->B   X ALU->C/status   W C->Rd
    //   I imm8->Rn     D addr calc    L latch address   R mem read
    //   Q mem read+write Rd           G read Rd->B      P pass B->C
    //   S mem write    J branch
    // ------------------------------------------------------------------
    bit          m_valid = 1'b0;
    bit          m_rst   = 1'b0;
    bit          m_halt  = 1'b0;
    logic [7:0]  m_pc    = 8'd0;
    logic [15:0] m_ir    = 16'd0;
    logic [8:0]  m_daddr = 9'd0;
    int          m_step  = 0;
    string       m_body  = "";

    function automatic string body_of(input logic [15:0] ir);
        case (ir[15:11])
            5'b11010:           return "I";
            5'b11000, 5'b10111: return "BXW";
            5'b10100, 5'b10110: return "ABXW";
            5'b10101:           return "ABX";
            5'b01100:           return "ADLRQ";
            5'b10000:           return "ADLGPS";
`ifdef CPU_BRANCH_EN
            5'b00100:           return "J";
`endif
            default:            return "";
        endcase
    endfunction

    function automatic bit taken(input logic [2:0] cond, input logic [2:0] st);
        bit z, n, v;
        z = st[0]; n = st[1]; v = st[2];
        case (cond)
            3'd0:    return 1'b1;
            3'd1:    return z;
            3'd2:    return !z;
            3'd3:    return n != v;
            3'd4:    return (n != v) || z;
            default: return 1'b0;
        endcase
    endfunction

    task automatic compare();
        logic [15:0] ir;
        byte  u;
        logic e_la, e_lb, e_lc, e_ls, e_wr, e_asel, e_halt;
        logic [2:0] e_rn, e_wn;
        logic [1:0] e_vsel, e_bsel, e_sh, e_alu, e_cmd;
        logic [8:0] e_addr;
        bit k_asel, k_sh;
        ir = m_ir;
        {e_la, e_lb, e_lc, e_ls, e_wr, e_asel, e_halt} = '0;
        e_rn = 0; e_wn = 0; e_vsel = 0; e_bsel = 0; e_sh = 0; e_alu = 0;
        e_cmd = 0; e_addr = 0; k_asel = 1; k_sh = 1;
        if (m_rst) begin
            // everything zero
        end else if (m_halt) begin
            e_halt = 1;
        end else if (m_step <= 1) begin
            e_cmd = 2'b01; e_addr = {1'b0, m_pc};
        end else if (m_step >= 4) begin
            u = m_body.getc(m_step - 4);
            case (u)
                "A": begin e_la = 1; e_rn = ir[10:8]; end
                "B": begin e_lb = 1; e_rn = ir[2:0]; end
                "X": begin
                    if (ir[15:11] == 5'b10101) e_ls = 1; else e_lc = 1;
                    e_asel = (ir[15:13] == 3'b110);
                    k_asel = (ir[15:11] != 5'b10111);
                    e_sh = ir[4:3]; e_alu = ir[12:11];
                end
                "W": begin e_wr = 1; e_vsel = 2'b00; e_wn = ir[7:5]; end
                "I": begin e_wr = 1; e_vsel = 2'b11; e_wn = ir[10:8]; end
                "D": begin e_lc = 1; e_bsel = 2'b01; k_sh = 0; end
                "R": begin e_cmd = 2'b01; e_addr = m_daddr; end
                "Q": begin
                    e_cmd = 2'b01; e_addr = m_daddr;
                    e_wr = 1; e_vsel = 2'b10; e_wn = ir[7:5];
                end
                "G": begin e_lb = 1; e_rn = ir[7:5]; end
                "P": begin e_lc = 1; e_asel = 1; end
                "S": begin e_cmd = 2'b10; e_addr = m_daddr; end
                default: ;
            endcase
        end
        if (reset) begin e_wr = 0; e_cmd = 0; end

        chk("strobes", {loada, loadb, loadc, loads, write, halted},
            {e_la, e_lb, e_lc, e_ls, e_wr, e_halt});
        chk("mem_cmd", mem_cmd, e_cmd);
        chk("pc", PC, m_pc);
        chk("sximm8", sximm8, {{8{ir[7]}}, ir[7:0]});
        chk("sximm5", sximm5, {{11{ir[4]}}, ir[4:0]});
        if (e_cmd != 0) chk("mem_addr", mem_addr, e_addr);
        if (e_la || e_lb) chk("readnum", readnum, e_rn);
        if (e_wr) chk("write_sel", {writenum, vsel}, {e_wn, e_vsel});
        if (e_lc || e_ls) begin
            chk("alu_ctl", {bsel, ALUop}, {e_bsel, e_alu});
            if (k_asel) chk("asel", asel, e_asel);
            if (k_sh) chk("shift", shift, e_sh);
        end
        if (m_rst)
            chk("rst_misc", {readnum, writenum, vsel, bsel, asel, shift, ALUop, mem_addr}, 0);
    endtask

    task automatic advance();
        byte u;
        if (reset) begin
            m_valid = 1; m_rst = 1; m_halt = 0; m_pc = 0; m_ir = 0;
            m_daddr = 0; m_step = 0;
        end else if (!m_valid || m_halt) begin
            // nothing changes
        end else if (m_rst) begin
            m_rst = 0; m_step = 0;
        end else begin
            case (m_step)
                1: m_ir = mem[{1'b0, m_pc}];
                2: m_pc = m_pc + 8'd1;
                3: begin
                    m_body = body_of(m_ir);
                    if (m_body.len() == 0) m_halt = 1;
                end
                default: begin
                    if (m_step >= 4) begin
                        u = m_body.getc(m_step - 4);
                        if (u == "L") m_daddr = datapath_out[8:0];
                        if (u == "J" && taken(m_ir[10:8], status_in))
                            m_pc = m_pc + m_ir[7:0];
                    end
                end
            endcase
            m_step++;
            if (m_step >= 4 && m_step == 4 + m_body.len()) m_step = 0;
        end
    endtask

    // One compare process: outputs are stable mid-cycle at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) compare();
            advance();
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
        if (rand_inputs) begin
            datapath_out = 16'($urandom);
            status_in    = 3'($urandom);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;   // the following cycle is the RST state
    endtask

    function automatic logic [15:0] rand_instr();
        logic [10:0] f;
        int k;
        f = 11'($urandom);
`ifdef CPU_BRANCH_EN
        k = $urandom_range(0, 8);
`else
        k = $urandom_range(0, 7);
`endif
        case (k)
            0:       return {5'b11010, f};
            1:       return {5'b11000, f};
            2:       return {5'b10100, f};
            3:       return {5'b10101, f};
            4:       return {5'b10110, f};
            5:       return {5'b10111, f};
            6:       return {5'b01100, f};
            7:       return {5'b10000, f};
            default: return {5'b00100, f};
        endcase
    endfunction

    initial begin
        reset        = 1'b1;
        datapath_out = 16'h0012;
        status_in    = 3'b001;
        for (int i = 0; i < 512; i++) mem[i] = 16'hE000;
        mem[0] = 16'hD001;  // MOV R0,#1
        mem[1] = 16'hA1A2;  // ADD R5,R1,R2
        mem[2] = 16'h6142;  // LDR R2,[R1,#2]
        mem[3] = 16'hE000;  // HALT

        // ---- reset and first fetch ----
        next_cycle();
        chk("reset_pc", PC, 8'h00);
        chk("reset_cmd", mem_cmd, 2'b00);
        next_cycle();
        reset = 1'b0;
        chk("rst_cmd", mem_cmd, 2'b00);
        chk("rst_halted", halted, 1'b0);
        next_cycle();
        chk("if1_cmd", mem_cmd, 2'b01);
        chk("if1_addr", mem_addr, 9'h000);
        cycles(3);
        chk("decode_pc", PC, 8'h01);

        // ---- MOV R0,#1 ----
        next_cycle();
        chk("wimm_ctl", {vsel, writenum, write}, {2'b11, 3'd0, 1'b1});
        chk("wimm_sximm8", sximm8, 16'h0001);
        next_cycle();
        chk("if1b_addr", mem_addr, 9'h001);
        chk("if1b_pc", PC, 8'h01);

        // ---- ADD R5,R1,R2 ----
        cycles(4);
        chk("geta", {readnum, loada}, {3'd1, 1'b1});
        next_cycle();
        chk("getb", {readnum, loadb}, {3'd2, 1'b1});
        next_cycle();
        chk("exec", {ALUop, loadc}, {2'b00, 1'b1});
        next_cycle();
        chk("wreg", {writenum, vsel, write}, {3'd5, 2'b00, 1'b1});
        next_cycle();
        chk("add_len_fetch", {mem_cmd, mem_addr}, {2'b01, 9'h002});

        // ---- LDR R2,[R1,#2] with C = 0x0012 ----
        cycles(7);
        chk("rd1", {mem_cmd, mem_addr}, {2'b01, 9'h012});
        next_cycle();
        chk("rd2_mem", {mem_cmd, mem_addr}, {2'b01, 9'h012});
        chk("rd2_wr", {writenum, vsel, write}, {3'd2, 2'b10, 1'b1});
        next_cycle();
        chk("ldr_len_fetch", mem_addr, 9'h003);

        // ---- HALT ----
        cycles(4);
        for (int i = 0; i < 10; i++) begin
            chk("halt", {halted, mem_cmd}, {1'b1, 2'b00});
            next_cycle();
        end

        // ---- reset in the middle of an LDR (RD1) ----
        mem[0] = 16'h6142;
        do_reset();
        cycles(8);
        chk("rd1_before_reset", mem_cmd, 2'b01);
        reset = 1'b1;
        #1;
        chk("rd1_reset_cmd", mem_cmd, 2'b00);
        next_cycle();
        reset = 1'b0;
        chk("abort_strobes", {loada, loadb, loadc, loads, write, mem_cmd}, 0);
        chk("abort_pc", PC, 8'h00);

        // ---- BEQ #3 at address 4 ----
        for (int i = 0; i < 9; i++) mem[i] = 16'hD001;
        mem[4] = 16'h2103;
        for (int s = 0; s < 2; s++) begin
            status_in = (s == 0) ? 3'b001 : 3'b000;
            do_reset();
            cycles(24);
            chk("br_decode_pc", PC, 8'h05);
            next_cycle();
`ifdef CPU_BRANCH_EN
            chk("br_halted", halted, 1'b0);
            next_cycle();
            chk("br_target", {PC, mem_addr}, (s == 0) ? {8'h08, 9'h008} : {8'h05, 9'h005});
`else
            chk("br_undef_halt", halted, 1'b1);
`endif
        end

        // ---- randomized programs, inputs and resets ----
        rand_inputs = 1'b1;
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 512; i++)
                mem[i] = (ph == 0 || $urandom_range(0, 1) == 0) ? rand_instr() : 16'($urandom);
            do_reset();
            for (int c = 0; c < 1500; c++) begin
                next_cycle();
                reset = ($urandom_range(0, (ph == 0) ? 199 : 24) == 0);
            end
        end
        reset = 1'b0;
        cycles(3);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Instruction-sequencing state machine for the simple RISC CPU.
- Owns the PC and the instruction register (IR).
- Fetches from memory and decodes each instruction into per-cycle control for the Datapath: readnum, vsel, loada, loadb, shift, asel, bsel, ALUop, loadc, loads, writenum, write, sximm8, PC, sximm5.
- Consumes datapath_out and status_out back from the Datapath.

Parameters:
- PC_W, 8, PC width; PC wraps modulo 2^PC_W.
- RESET_PC, 0, PC value loaded in reset and in the RST state.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- read_data  in  16  memory read data, valid during a cycle with mem_cmd=READ.
- datapath_out  in  16  Datapath C register (load/store address source).
- status_in  in  3  Datapath status_out: [2]=V, [1]=N, [0]=Z.
- readnum, writenum  out  3 each  register selects.
- vsel  out  2  00=C, 01=PC, 10=mdata, 11=sximm8.
- bsel  out  2  00=shifted B, 01=sximm5, 10=sximm8.
- asel  out  1  0=A, 1=zero.
- loada, loadb, loadc, loads, write  out  1 each  datapath strobes.
- shift, ALUop  out  2 each  from IR[4:3] and IR[12:11] respectively (shift forced 00 where stated).
- sximm8, sximm5  out  16 each  sign-extended IR[7:0], IR[4:0].
- PC  out  PC_W  current PC.
- mem_cmd  out  2  00=NONE, 01=READ, 10=WRITE.
- mem_addr  out  9  fetch address {0,PC} or data address register.
- halted  out  1  high in HALT state.

Behaviour:
- Moore outputs decoded from state and IR. Every strobe is 0 unless listed for the state.
- Reset: state←RST, IR←0, PC←RESET_PC, data address←0. While in RST all outputs are 0 and mem_cmd=NONE.
- Reset asserted mid-instruction aborts it; no write or mem_cmd strobe is issued on the reset cycle.
- Field map: opcode IR[15:13], op IR[12:11], Rn IR[10:8], Rd IR[7:5], Rm IR[2:0], cond IR[10:8].
- Common sequence, one cycle each:
  - RST → IF1.
  - IF1: mem_cmd=READ, mem_addr={0,PC}.
  - IF2: as IF1; IR←read_data at the edge.
  - UPDATE_PC: PC←PC+1.
  - DECODE → dispatch.
- MOV imm (110 10): WIMM (vsel=11, writenum=Rn, write) → IF1.
- MOV reg (110 00): GETB (readnum=Rm, loadb) → EXEC (asel=1, bsel=00, ALUop=00, loadc) → WREG (vsel=00, writenum=Rd, write) → IF1.
- ADD/AND (101 00/10): GETA (readnum=Rn, loada) → GETB → EXEC (asel=0, ALUop=op, loadc) → WREG.
- CMP (101 01): GETA → GETB → EXEC with loads=1, loadc=0 → IF1. Registers are unchanged.
- MVN (101 11): GETB → EXEC → WREG.
- LDR (011 00):
  - GETA → ADDR (asel=0, bsel=01, ALUop=00, loadc).
  - LADDR: data address ← datapath_out[8:0].
  - RD1: mem_cmd=READ, mem_addr=data address.
  - RD2: as RD1 plus vsel=10, writenum=Rd, write → IF1.
- STR (100 00):
  - GETA → ADDR → LADDR.
  - GETD: readnum=Rd, loadb.
  - PASS: asel=1, bsel=00, shift=00, ALUop=00, loadc.
  - WR: mem_cmd=WRITE, mem_addr=data address → IF1.
- HALT (111 00): HALT state, halted=1, mem_cmd=NONE. Stays until reset.
- Any other encoding → HALT.
- Latency, reset release to first IF1: 1 cycle (RST).
- Instruction cycle counts including fetch/decode:
  - MOV imm: 5.
  - MOV reg / MVN: 7.
  - ADD / AND: 8.
  - CMP: 7.
  - LDR: 9.
  - STR: 10.
  - B: 5.
- PC wrap: 0xFF+1 → 0x00.
- Branch target arithmetic is modulo 2^PC_W using sximm8 truncated to PC_W.

Optional Feature:
- Macro: CPU_BRANCH_EN.
- Defined: opcode 001 op 00 is decoded to BRANCH (1 cycle). If the condition holds, PC←PC+sximm8, where PC has already been incremented; then → IF1. Conditions:
  - cond 000: B, always.
  - 001: BEQ, Z.
  - 010: BNE, !Z.
  - 011: BLT, N≠V.
  - 100: BLE, N≠V or Z.
  - Other cond values: not taken.
- status_in is sampled in the BRANCH cycle.
- Undefined: opcode 001 → HALT.

Test Plan:
- Reset for 2 cycles, release → RST for 1 cycle, then IF1 with mem_cmd=01, mem_addr=0x000. UPDATE_PC makes PC=1.
- IR=0xD001 (MOV R0,#1) → WIMM: vsel=11, writenum=0, write=1, sximm8=0x0001. Next state IF1 with PC=1.
- IR=0xA1A2 (ADD R5,R1,R2) → GETA readnum=1 loada; GETB readnum=2 loadb; EXEC ALUop=00 loadc; WREG writenum=5 vsel=00 write. 8 cycles total.
- IR=0x6142 (LDR R2,[R1,#2]) with datapath_out=0x0012 → RD1/RD2 mem_addr=0x012, mem_cmd=01; RD2 writenum=2 vsel=10 write=1.
- With CPU_BRANCH_EN and PC=0x05 after fetch: IR=0x2103 (BEQ #3), status_in=001 → PC=0x08. With status_in=000 → PC stays 0x05. With macro undefined → halted=1.
- IR=0xE000 (HALT) → halted=1, mem_cmd=00 for 10 cycles. Reset asserted mid-LDR (state RD1) → next cycle RST, all strobes 0, PC=RESET_PC.
